// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: latches handshake/DATA requests and sequences usb_tx commands.
// Define USB_TX_SCHED_TIMEOUT_EN to drop a packet when usb_tx never starts.
module usb_tx_scheduler #(
    parameter int ISSUE_CYCLES   = 8,
    parameter int IPG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_PKT_SIZE   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ack_req,
    input  logic       nak_req,
    input  logic       data_req,
    input  logic [6:0] data_req_size,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    output logic [1:0] tx_packet,
    output logic [6:0] tx_packet_size,
    output logic       hs_sent,
    output logic       data_sent,
    output logic       req_reject,
    output logic       tx_timeout,
    output logic       sched_busy
);

    localparam int ISSUE_W = ($clog2(ISSUE_CYCLES) > 4) ? $clog2(ISSUE_CYCLES) : 4;
    localparam int GAP_W   = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;

    localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(ISSUE_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(IPG_CYCLES - 1);
    localparam logic [6:0]         MAX_SIZE   = 7'(MAX_PKT_SIZE);
    localparam logic [1:0]         CODE_DATA  = 2'b01;
    localparam logic [1:0]         CODE_NAK   = 2'b10;
    localparam logic [1:0]         CODE_ACK   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACTIVE,
        BUSY,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         hs_slot;
    logic               data_valid;
    logic [6:0]         data_size;
    logic [1:0]         cur_code;
    logic [ISSUE_W-1:0] issue_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               start_hs;
    logic               start_data;
    logic               end_sent;
    logic               data_accept;

    assign data_accept = data_req && !data_valid && (data_req_size <= MAX_SIZE);

`ifdef USB_TX_SCHED_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            end_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt     <= '0;
            tx_timeout <= 1'b0;
        end else begin
            if (state != WAIT_ACTIVE) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + 1'b1;
            end
            tx_timeout <= end_timeout;
        end
    end
`else
    assign tx_timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        start_hs   = 1'b0;
        start_data = 1'b0;
        end_sent   = 1'b0;
`ifdef USB_TX_SCHED_TIMEOUT_EN
        end_timeout = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Handshakes always go first; a starved DATA slot never blocks them.
                if (hs_slot != 2'b00) begin
                    state_next = ISSUE;
                    start_hs   = 1'b1;
                end else if (data_valid && (buffer_occupancy >= data_size)) begin
                    state_next = ISSUE;
                    start_data = 1'b1;
                end
            end
            ISSUE: begin
                if (issue_cnt == ISSUE_LAST) begin
                    state_next = WAIT_ACTIVE;
                end
            end
            WAIT_ACTIVE: begin
                if (tx_transfer_active) begin
                    state_next = BUSY;
                end
`ifdef USB_TX_SCHED_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    state_next  = GAP;
                    end_timeout = 1'b1;
                end
`endif
            end
            BUSY: begin
                if (!tx_transfer_active) begin
                    state_next = GAP;
                    end_sent   = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            hs_slot        <= 2'b00;
            data_valid     <= 1'b0;
            data_size      <= '0;
            cur_code       <= 2'b00;
            issue_cnt      <= '0;
            gap_cnt        <= '0;
            tx_packet      <= 2'b00;
            tx_packet_size <= '0;
            hs_sent        <= 1'b0;
            data_sent      <= 1'b0;
            req_reject     <= 1'b0;
            sched_busy     <= 1'b0;
        end else begin
            state <= state_next;

            // A request arriving on the cycle its slot is serviced is kept, not lost.
            if (ack_req) begin
                hs_slot <= CODE_ACK;
            end else if (nak_req) begin
                hs_slot <= CODE_NAK;
            end else if (start_hs) begin
                hs_slot <= 2'b00;
            end

            if (data_accept) begin
                data_valid <= 1'b1;
                data_size  <= data_req_size;
            end else if (start_data) begin
                data_valid <= 1'b0;
            end

            if (start_hs) begin
                cur_code       <= hs_slot;
                tx_packet_size <= '0;
            end else if (start_data) begin
                cur_code       <= CODE_DATA;
                tx_packet_size <= data_size;
            end

            if (state != ISSUE) begin
                issue_cnt <= '0;
            end else if (issue_cnt != ISSUE_LAST) begin
                issue_cnt <= issue_cnt + 1'b1;
            end

            if (state != GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            tx_packet  <= (state == ISSUE) ? cur_code : 2'b00;
            hs_sent    <= end_sent && (cur_code != CODE_DATA);
            data_sent  <= end_sent && (cur_code == CODE_DATA);
            req_reject <= data_req && !data_accept;
            sched_busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb_usb_tx_scheduler: directed and random stimulus against a timeline-based model
// of the scheduler, with a small usb_tx responder driving tx_transfer_active.
module tb_usb_tx_scheduler;

    localparam int ISSUE_CYCLES   = 8;
    localparam int IPG_CYCLES     = 16;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int MAX_PKT_SIZE   = 64;
`ifdef USB_TX_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ack_req = 1'b0;
    logic       nak_req = 1'b0;
    logic       data_req = 1'b0;
    logic [6:0] data_req_size = '0;
    logic [6:0] buffer_occupancy = '0;
    logic       tx_transfer_active = 1'b0;
    logic [1:0] tx_packet;
    logic [6:0] tx_packet_size;
    logic       hs_sent;
    logic       data_sent;
    logic       req_reject;
    logic       tx_timeout;
    logic       sched_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usb_tx_scheduler #(
        .ISSUE_CYCLES  (ISSUE_CYCLES),
        .IPG_CYCLES    (IPG_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_PKT_SIZE  (MAX_PKT_SIZE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ack_req           (ack_req),
        .nak_req           (nak_req),
        .data_req          (data_req),
        .data_req_size     (data_req_size),
        .buffer_occupancy  (buffer_occupancy),
        .tx_transfer_active(tx_transfer_active),
        .tx_packet         (tx_packet),
        .tx_packet_size    (tx_packet_size),
        .hs_sent           (hs_sent),
        .data_sent         (data_sent),
        .req_reject        (req_reject),
        .tx_timeout        (tx_timeout),
        .sched_busy        (sched_busy)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", name, actual, expected, $time);
        end
    endtask

    // Model: packets are tracked as a timeline of edge numbers rather than states.
    int n = 0;
    int m_hs = 0;
    bit m_dv = 0;
    bit m_old_dv = 0;
    int m_dsize = 0;
    bit m_inflight = 0;
    int m_code = 0;
    int m_issue_edge = 0;
    bit m_started = 0;
    int m_busy_edge = 0;
    int m_free_at = 0;
    int exp_tx_packet = 0;
    int exp_size = 0;
    bit exp_size_valid = 0;
    bit exp_hs_sent = 0;
    bit exp_data_sent = 0;
    bit exp_reject = 0;
    bit exp_timeout = 0;
    bit exp_busy = 0;
    bit compare_en = 0;

    always @(posedge clk) begin
        n = n + 1;
        exp_hs_sent   = 0;
        exp_data_sent = 0;
        exp_reject    = 0;
        exp_timeout   = 0;
        if (rst) begin
            m_hs       = 0;
            m_dv       = 0;
            m_dsize    = 0;
            m_inflight = 0;
            m_started  = 0;
            m_free_at  = n;
            exp_size   = 0;
        end else begin
            m_old_dv = m_dv;
            if (m_inflight) begin
                if (!m_started) begin
                    if (n > m_issue_edge + ISSUE_CYCLES) begin
                        if (tx_transfer_active) begin
                            m_started   = 1;
                            m_busy_edge = n;
                        end else if (TIMEOUT_EN &&
                                     n == m_issue_edge + ISSUE_CYCLES + TIMEOUT_CYCLES) begin
                            exp_timeout = 1;
                            m_inflight  = 0;
                            m_free_at   = n + IPG_CYCLES;
                        end
                    end
                end else if (n > m_busy_edge && !tx_transfer_active) begin
                    if (m_code == 1) exp_data_sent = 1;
                    else exp_hs_sent = 1;
                    m_inflight = 0;
                    m_free_at  = n + IPG_CYCLES;
                end
            end else if (n > m_free_at) begin
                if (m_hs != 0) begin
                    m_inflight = 1; m_started = 0; m_issue_edge = n;
                    m_code = m_hs; exp_size = 0; m_hs = 0;
                end else if (m_dv && int'(buffer_occupancy) >= m_dsize) begin
                    m_inflight = 1; m_started = 0; m_issue_edge = n;
                    m_code = 1; exp_size = m_dsize; m_dv = 0;
                end
            end
            if (ack_req) m_hs = 3;
            else if (nak_req) m_hs = 2;
            if (data_req) begin
                if (int'(data_req_size) > MAX_PKT_SIZE || m_old_dv) begin
                    exp_reject = 1;
                end else begin
                    m_dv    = 1;
                    m_dsize = int'(data_req_size);
                end
            end
        end
        exp_tx_packet  = (m_inflight && n >= m_issue_edge + 1 &&
                          n <= m_issue_edge + ISSUE_CYCLES) ? m_code : 0;
        exp_busy       = m_inflight || (n < m_free_at);
        exp_size_valid = m_inflight;
    end

    always @(negedge clk) begin
        if (compare_en) begin
            check_output("tx_packet", int'(tx_packet), exp_tx_packet);
            check_output("hs_sent", int'(hs_sent), int'(exp_hs_sent));
            check_output("data_sent", int'(data_sent), int'(exp_data_sent));
            check_output("req_reject", int'(req_reject), int'(exp_reject));
            check_output("tx_timeout", int'(tx_timeout), int'(exp_timeout));
            check_output("sched_busy", int'(sched_busy), int'(exp_busy));
            if (exp_size_valid) check_output("tx_packet_size", int'(tx_packet_size), exp_size);
        end
    end

    // usb_tx responder and event monitor, both stepped from the stimulus process.
    int r_phase = 0, r_cnt = 0, r_delay = 10, r_len = 200;
    bit r_rand = 0, r_dead = 0, r_prev = 0;
    int cyc = 0, tx_cycles = 0, first_tx_cyc = -1, last_hs_cyc = -1, busy_fall_cyc = -1;
    int hs_cnt = 0, data_cnt = 0, rej_cnt = 0, to_cnt = 0, to_cyc = -1;
    int issued_codes[$];
    int issued_sizes[$];
    logic [1:0] prev_tx = 2'b00;
    logic prev_busy = 1'b0;
    logic [6:0] occ = '0;

    task automatic clear_mon();
        tx_cycles = 0; first_tx_cyc = -1; last_hs_cyc = -1; busy_fall_cyc = -1;
        hs_cnt = 0; data_cnt = 0; rej_cnt = 0; to_cnt = 0; to_cyc = -1;
        issued_codes.delete();
        issued_sizes.delete();
    endtask

    task automatic update_responder();
        if (rst) begin
            r_phase = 0;
            tx_transfer_active = 1'b0;
            r_prev = 0;
        end else begin
            case (r_phase)
                0: if (tx_packet != 2'b00 && !r_prev && !r_dead) begin
                    if (r_rand) begin
                        r_delay = $urandom_range(1, 12);
                        r_len   = $urandom_range(10, 25);
                    end
                    r_phase = 1;
                    r_cnt   = r_delay;
                end
                1: begin
                    r_cnt--;
                    if (r_cnt <= 0) begin
                        tx_transfer_active = 1'b1;
                        r_phase = 2;
                        r_cnt   = r_len;
                    end
                end
                default: begin
                    r_cnt--;
                    if (r_cnt <= 0) begin
                        tx_transfer_active = 1'b0;
                        r_phase = 0;
                    end
                end
            endcase
            r_prev = (tx_packet != 2'b00);
        end
    endtask

    task automatic apply_stimulus(input logic a, input logic k, input logic d,
                                  input logic [6:0] sz, input logic r);
        @(negedge clk);
        cyc++;
        if (tx_packet != 2'b00) begin
            tx_cycles++;
            if (prev_tx == 2'b00) begin
                issued_codes.push_back(int'(tx_packet));
                issued_sizes.push_back(int'(tx_packet_size));
                if (first_tx_cyc < 0) first_tx_cyc = cyc;
            end
        end
        prev_tx = tx_packet;
        if (hs_sent) begin hs_cnt++; last_hs_cyc = cyc; end
        if (data_sent) data_cnt++;
        if (req_reject) rej_cnt++;
        if (tx_timeout) begin to_cnt++; to_cyc = cyc; end
        if (prev_busy && !sched_busy) busy_fall_cyc = cyc;
        prev_busy = sched_busy;
        update_responder();
        ack_req          = a;
        nak_req          = k;
        data_req         = d;
        data_req_size    = sz;
        rst              = r;
        buffer_occupancy = occ;
    endtask

    task automatic idle_cycles(input int count);
        for (int i = 0; i < count; i++) apply_stimulus(0, 0, 0, 7'd0, 0);
    endtask

    function automatic int code_at(input int idx);
        return (issued_codes.size() > idx) ? issued_codes[idx] : -1;
    endfunction

    function automatic int size_at(input int idx);
        return (issued_sizes.size() > idx) ? issued_sizes[idx] : -1;
    endfunction

    int start_cyc;
    int waited;

    initial begin
        apply_stimulus(0, 0, 0, 7'd0, 1);
        compare_en = 1;
        apply_stimulus(0, 0, 0, 7'd0, 1);
        apply_stimulus(0, 0, 0, 7'd0, 1);
        apply_stimulus(0, 0, 0, 7'd0, 0);
        apply_stimulus(0, 0, 0, 7'd0, 0);
        check_output("reset_tx_packet", int'(tx_packet), 0);
        check_output("reset_size", int'(tx_packet_size), 0);
        check_output("reset_pulses", int'({hs_sent, data_sent, req_reject, tx_timeout}), 0);
        check_output("reset_busy", int'(sched_busy), 0);

        $display("[TB] single ACK with long transfer");
        clear_mon();
        apply_stimulus(1, 0, 0, 7'd0, 0);
        start_cyc = cyc;
        idle_cycles(280);
        check_output("ack_latency", first_tx_cyc - start_cyc, 3);
        check_output("ack_hold_cycles", tx_cycles, 8);
        check_output("ack_code", code_at(0), 3);
        check_output("ack_size", size_at(0), 0);
        check_output("ack_hs_sent_count", hs_cnt, 1);
        check_output("ack_busy_after_gap", busy_fall_cyc - last_hs_cyc, 16);

        $display("[TB] ACK+NAK together with DATA size 2");
        r_len = 20;
        occ = 7'd2;
        clear_mon();
        apply_stimulus(1, 1, 1, 7'd2, 0);
        idle_cycles(200);
        check_output("both_issue_count", issued_codes.size(), 2);
        check_output("both_first_code", code_at(0), 3);
        check_output("both_second_code", code_at(1), 1);
        check_output("both_data_size", size_at(1), 2);
        check_output("both_data_sent_count", data_cnt, 1);

        $display("[TB] DATA waits on occupancy while NAK passes");
        occ = 7'd3;
        clear_mon();
        apply_stimulus(0, 0, 1, 7'd5, 0);
        idle_cycles(50);
        check_output("starved_issue_count", issued_codes.size(), 0);
        apply_stimulus(0, 1, 0, 7'd0, 0);
        idle_cycles(80);
        check_output("nak_code", code_at(0), 2);
        occ = 7'd5;
        idle_cycles(80);
        check_output("late_data_code", code_at(1), 1);
        check_output("late_data_size", size_at(1), 5);
        clear_mon();
        apply_stimulus(0, 0, 1, 7'd65, 0);
        idle_cycles(40);
        check_output("oversize_reject", rej_cnt, 1);
        check_output("oversize_issue_count", issued_codes.size(), 0);

        $display("[TB] second DATA request while slot full");
        occ = 7'd0;
        clear_mon();
        apply_stimulus(0, 0, 1, 7'd7, 0);
        apply_stimulus(0, 0, 1, 7'd3, 0);
        idle_cycles(5);
        check_output("full_slot_reject", rej_cnt, 1);
        occ = 7'd10;
        idle_cycles(80);
        check_output("kept_data_code", code_at(0), 1);
        check_output("kept_data_size", size_at(0), 7);

`ifdef USB_TX_SCHED_TIMEOUT_EN
        $display("[TB] usb_tx never starts");
        r_dead = 1;
        clear_mon();
        apply_stimulus(0, 0, 1, 7'd1, 0);
        idle_cycles(120);
        check_output("timeout_count", to_cnt, 1);
        check_output("timeout_latency", to_cyc - first_tx_cyc, 71);
        check_output("timeout_no_data_sent", data_cnt, 0);
        r_dead = 0;
        idle_cycles(30);
`endif

        $display("[TB] reset while BUSY");
        r_len = 200;
        clear_mon();
        apply_stimulus(1, 0, 0, 7'd0, 0);
        waited = 0;
        while (!(tx_transfer_active && tx_packet == 2'b00) && waited < 100) begin
            apply_stimulus(0, 0, 0, 7'd0, 0);
            waited++;
        end
        check_output("reached_busy", int'(waited < 100), 1);
        idle_cycles(3);
        check_output("busy_before_reset", int'(sched_busy), 1);
        apply_stimulus(0, 0, 0, 7'd0, 1);
        apply_stimulus(0, 0, 0, 7'd0, 0);
        check_output("busy_reset_tx_packet", int'(tx_packet), 0);
        check_output("busy_reset_busy", int'(sched_busy), 0);

        $display("[TB] random traffic");
        r_rand = 1;
        clear_mon();
        for (int i = 0; i < 4000 && failures <= 30; i++) begin
            if ($urandom_range(0, 19) == 0) occ = 7'($urandom_range(0, 70));
            if (TIMEOUT_EN && $urandom_range(0, 299) == 0) r_dead = !r_dead;
            apply_stimulus($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                           $urandom_range(0, 24) == 0, 7'($urandom_range(0, 70)),
                           $urandom_range(0, 599) == 0);
        end
        r_dead = 0;
        idle_cycles(5);
`ifndef USB_TX_SCHED_TIMEOUT_EN
        check_output("no_timeout_pulses", to_cnt, 0);
`endif
        compare_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
Sequencer in front of usb_tx. It latches transmit requests from the RX protocol decoder (ACK/NAK handshakes) and from the AHB-Lite slave (DATA packets). It arbitrates between them and drives usb_tx's tx_packet/tx_packet_size command interface with the required hold time. It tracks each transfer to completion through tx_transfer_active and enforces an inter-packet gap before the next command.

Parameters:
ISSUE_CYCLES, 8, clk cycles tx_packet is held non-idle (one USB bit time)
IPG_CYCLES, 16, clk cycles of idle gap after each packet end
TIMEOUT_CYCLES, 64, max clk cycles waiting for usb_tx to start (timeout feature only)
MAX_PKT_SIZE, 64, largest legal DATA payload in bytes

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ack_req  in  1  one-cycle pulse: queue ACK handshake
nak_req  in  1  one-cycle pulse: queue NAK handshake
data_req  in  1  one-cycle pulse: queue DATA packet
data_req_size  in  7  payload bytes for data_req, sampled with it
buffer_occupancy  in  7  bytes currently in TX FIFO
tx_transfer_active  in  1  high while usb_tx is serialising a packet
tx_packet  out  2  command to usb_tx: 00 idle, 01 DATA, 10 NAK, 11 ACK
tx_packet_size  out  7  payload size to usb_tx
hs_sent  out  1  one-cycle pulse: handshake packet finished
data_sent  out  1  one-cycle pulse: DATA packet finished
req_reject  out  1  one-cycle pulse: data_req refused
tx_timeout  out  1  one-cycle pulse: usb_tx never started
sched_busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset clears pending slots, counters and state to IDLE and takes effect on the next edge, including mid-packet. tx_packet returns to 00 the cycle after rst is sampled.
- Handshake slot (2 bits):
  - ack_req or nak_req loads the slot. A newer handshake overwrites an unserviced one.
  - ack_req and nak_req in the same cycle: ACK is stored.
- Data slot: valid bit plus 7-bit size.
  - data_req is rejected (req_reject pulse, slot unchanged) if data_req_size > MAX_PKT_SIZE or the data slot is already valid.
  - data_req_size = 0 is legal (zero-length packet).
- Requests are latched in every state, including during active transfers.
- States: IDLE, ISSUE, WAIT_ACTIVE, BUSY, GAP.
- IDLE:
  - Handshake slot valid -> ISSUE with ACK/NAK. Handshakes always win over data.
  - Otherwise, data slot valid and buffer_occupancy >= size -> ISSUE with DATA.
  - A data slot with insufficient occupancy waits without blocking handshakes.
- ISSUE:
  - tx_packet holds the code for exactly ISSUE_CYCLES cycles, then returns to 00. The slot is cleared on entry.
  - tx_packet_size = latched size for DATA, 0 for handshakes. It is held stable from ISSUE through BUSY.
  - Next state: WAIT_ACTIVE.
- Latency: a request sampled at edge t with the scheduler in IDLE gives tx_packet non-idle from edge t+2.
- WAIT_ACTIVE: tx_transfer_active=1 -> BUSY. If tx_transfer_active is already high on entry, go to BUSY next cycle.
- BUSY: tx_transfer_active=0 -> pulse hs_sent or data_sent for one cycle, then GAP.
- GAP: down-counter of IPG_CYCLES, then IDLE. Requests arriving in GAP are served from IDLE afterwards.
- Counters saturate and never wrap. The issue counter is 4 bits minimum; the gap and timeout counters are sized by $clog2 of their parameters.

Optional Feature:
Macro USB_TX_SCHED_TIMEOUT_EN.
- Defined:
  - WAIT_ACTIVE counts cycles. On reaching TIMEOUT_CYCLES: pulse tx_timeout, drop the packet (no sent pulse), go to GAP.
- Undefined:
  - WAIT_ACTIVE waits indefinitely. tx_timeout is tied to 0 and the timeout counter is not synthesised.

Test Plan:
- rst high 3 cycles, then release -> all outputs 0, sched_busy 0; rst asserted during BUSY -> tx_packet 00 and sched_busy 0 the next cycle.
- ack_req pulse, model usb_tx raises tx_transfer_active 10 cycles after issue for 200 cycles -> tx_packet=11 for 8 cycles from edge t+2, tx_packet_size=0; hs_sent pulses once when active falls; sched_busy falls 16 cycles later.
- ack_req and nak_req together, plus data_req size 2 with buffer_occupancy=2 -> ACK (11) issued first, NAK never issued, DATA (01, size 2) issued after the gap; data_sent pulses once.
- data_req size 5 with buffer_occupancy=3 for 50 cycles, then nak_req -> NAK issued while data waits; occupancy raised to 5 -> DATA issued with size 5. data_req size 65 -> req_reject pulse, nothing issued.
- Second data_req while data slot valid -> req_reject pulse; original size preserved. With USB_TX_SCHED_TIMEOUT_EN, tx_transfer_active held 0 -> tx_timeout pulse 64 cycles after WAIT_ACTIVE entry, no data_sent.
